btn_irq_ctrl: RTL



---
 rtl/btn_irq_pkg.sv | 25 ++
 rtl/irq_holdoff_timer.sv | 44 ++++
 rtl/btn_irq_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/btn_irq_pkg.sv
// ============================================================================
// Module   : btn_irq_pkg
// Brief    : Shared types and helpers for the push-button interrupt controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package btn_irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Bits needed to hold the hold-off reload value; never narrower than 1.
    function automatic int holdoff_tmr_w(input int holdoff);
        int w;
        w = $clog2(holdoff + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/irq_holdoff_timer.sv
// ============================================================================
// Module   : irq_holdoff_timer
// Brief    : Loadable down-counter that stops at zero; done flags zero.
// Revision : 1.0
// ============================================================================
`default_nettype none

module irq_holdoff_timer #(
    parameter int HOLDOFF = 16,
    parameter int TMR_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam logic [TMR_W-1:0] C_LOAD_VAL = (HOLDOFF > 0) ? TMR_W'(HOLDOFF - 1) : '0;

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = C_LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - TMR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/btn_irq_ctrl.sv
// ============================================================================
// Module   : btn_irq_ctrl
// Brief    : Level interrupt from debounced press pulses, with press counting,
//            overflow flag and a minimum low time between assertions.
// Revision : 1.0
// ============================================================================
`default_nettype none

module btn_irq_ctrl
    import btn_irq_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int HOLDOFF = 16,
    parameter int TOT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_pls,
    input  logic             irq_en,
    input  logic             irq_ack,
    output logic             irq,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             ovf,
    output logic [TOT_W-1:0] total_cnt
);

    localparam int               C_TMR_W    = holdoff_tmr_w(HOLDOFF);
    localparam logic [CNT_W-1:0] C_PEND_MAX = '1;

    state_t             state_q, state_d;
    logic               irq_q, irq_d;
    logic [CNT_W-1:0]   pend_q, pend_d;
    logic               ovf_q, ovf_d;
    logic [TOT_W-1:0]   total_q, total_d;
    logic               in_ho_q, in_ho_d;

    logic               ack_acc;
    logic               pend_sat;
    logic               tmr_load;
    logic               tmr_done;

    irq_holdoff_timer #(
        .HOLDOFF (HOLDOFF),
        .TMR_W   (C_TMR_W)
    ) u_holdoff_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .done (tmr_done)
    );

    // The timer is loaded in the first cycle spent in HOLDOFF, so irq stays
    // low for HOLDOFF+1 cycles after the acknowledging edge.
    always_comb begin
        state_d  = state_q;
        ack_acc  = (state_q == ST_PENDING) && irq_ack;
        in_ho_d  = (state_q == ST_HOLDOFF);
        tmr_load = (state_q == ST_HOLDOFF) && !in_ho_q;
        unique case (state_q)
            ST_IDLE: begin
                if (irq_en && (btn_pls || (pend_q != '0))) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (irq_ack) begin
                    state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLDOFF;
                end else if (!irq_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLDOFF: begin
                if (in_ho_q && tmr_done) begin
                    state_d = (irq_en && (pend_q != '0)) ? ST_PENDING : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        irq_d = (state_d == ST_PENDING);
    end

    always_comb begin
        pend_sat = (pend_q == C_PEND_MAX);
        pend_d   = pend_q;
        ovf_d    = ovf_q;
        if (ack_acc) begin
            pend_d = CNT_W'(btn_pls);
        end else if (btn_pls && !pend_sat) begin
            pend_d = pend_q + CNT_W'(1);
        end
        // A dropped pulse is only possible when no ack clears the counter.
        if (btn_pls && pend_sat && !ack_acc) begin
            ovf_d = 1'b1;
        end else if (ack_acc) begin
            ovf_d = 1'b0;
        end
        total_d = total_q + TOT_W'(btn_pls);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
            pend_q  <= '0;
            ovf_q   <= 1'b0;
            total_q <= '0;
            in_ho_q <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            total_q <= total_d;
            in_ho_q <= in_ho_d;
        end
    end

    assign irq       = irq_q;
    assign pend_cnt  = pend_q;
    assign ovf       = ovf_q;
    assign total_cnt = total_q;

endmodule

`default_nettype wire
